// File: rtl/coin_button_scanner.sv
// Five-button vending-machine front end: synchronise, debounce, queue presses as pending
// bits and hand them to the consumer one at a time through a two-state holding register.
module coin_button_scanner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [4:0] BTN,
    input  logic       coin_ready,
    output logic       coin_valid,
    output logic [2:0] coin_code,
    output logic       overflow,
    output logic [4:0] btn_level
);

    localparam int NumBtn = 5;
    localparam int CntW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        StEmpty,
        StFull
    } state_e;

    logic [4:0]      sync1_q;
    logic [4:0]      sync2_q;
    logic [CntW-1:0] cnt_q [NumBtn];
    logic [CntW-1:0] cnt_d [NumBtn];
    logic [4:0]      level_q;
    logic [4:0]      level_d;
    logic [4:0]      press;
    logic [4:0]      pending_q;
    logic [4:0]      pending_d;
    logic [4:0]      load_mask;
    logic [2:0]      load_code;
    logic            overflow_q;
    logic            overflow_d;
    state_e          state_q;
    logic            valid_q;
    logic [2:0]      code_q;

    // Two-flop synchroniser on every raw button.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= BTN;
            sync2_q <= sync1_q;
        end
    end

    // Level flips on the DEBOUNCE_CYCLES-th consecutive mismatching cycle; only rising
    // flips count as presses.
    always_comb begin
        level_d = level_q;
        press   = '0;
        for (int i = 0; i < NumBtn; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    level_d[i] = ~level_q[i];
                    press[i]   = ~level_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NumBtn; i++) begin
                cnt_q[i] <= '0;
            end
            level_q <= '0;
        end else begin
            for (int i = 0; i < NumBtn; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            level_q <= level_d;
        end
    end

    // Lowest-index pending bit wins; loading only happens while the holder is empty.
    always_comb begin
        load_mask = '0;
        load_code = '0;
        if (state_q == StEmpty) begin
            for (int i = NumBtn - 1; i >= 0; i--) begin
                if (pending_q[i]) begin
                    load_mask    = '0;
                    load_mask[i] = 1'b1;
                    load_code    = 3'(i + 1);
                end
            end
        end
    end

    // A press landing on the edge its pending bit is being loaded re-arms it without overflow.
    always_comb begin
        pending_d  = (pending_q & ~load_mask) | press;
        overflow_d = |(press & pending_q & ~load_mask);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StEmpty;
            valid_q <= 1'b0;
            code_q  <= '0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (|pending_q) begin
                        state_q <= StFull;
                        valid_q <= 1'b1;
                        code_q  <= load_code;
                    end
                end
                StFull: begin
                    if (coin_ready) begin
                        state_q <= StEmpty;
                        valid_q <= 1'b0;
                        code_q  <= '0;
                    end
                end
                default: begin
                    state_q <= StEmpty;
                    valid_q <= 1'b0;
                    code_q  <= '0;
                end
            endcase
        end
    end

    assign coin_valid = valid_q;
    assign coin_code  = code_q;
    assign overflow   = overflow_q;
    assign btn_level  = level_q;

endmodule

// File: tb/tb_coin_button_scanner.sv
// Directed scenarios plus random button traffic, every cycle compared against a
// history-window reference model of the scanner.
module tb_coin_button_scanner;

    localparam int D = 4;

    logic       CLK;
    logic       RST;
    logic [4:0] BTN;
    logic       coin_ready;
    logic       coin_valid;
    logic [2:0] coin_code;
    logic       overflow;
    logic [4:0] btn_level;

    int errors = 0;
    int checks = 0;

    coin_button_scanner #(
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .BTN       (BTN),
        .coin_ready(coin_ready),
        .coin_valid(coin_valid),
        .coin_code (coin_code),
        .overflow  (overflow),
        .btn_level (btn_level)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Reference model: raw samples per edge, newest first.
    logic [4:0] hist[$];
    logic [4:0] m_level;
    logic [4:0] m_pend;
    int         m_hold;
    logic       m_ovf;

    // Scenario observation counters.
    int         deliv;
    int         deliv3;
    int         ovf_cnt;
    logic [4:0] level_seen;
    int         codes[$];

    function automatic logic [4:0] h(int k);
        if (k < hist.size()) return hist[k];
        return '0;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_level = '0;
        m_pend  = '0;
        m_hold  = 0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_edge();
        logic [4:0] press;
        logic [4:0] loaded;
        logic [4:0] s;
        logic       all_diff;
        if (RST) begin
            model_reset();
            return;
        end
        press = '0;
        // Synchronised value seen at this edge is the raw sample from two edges back.
        for (int i = 0; i < 5; i++) begin
            all_diff = 1'b1;
            for (int k = 1; k <= D; k++) begin
                s = h(k);
                if (s[i] == m_level[i]) all_diff = 1'b0;
            end
            if (all_diff) begin
                m_level[i] = ~m_level[i];
                press[i]   = m_level[i];
            end
        end
        hist.push_front(BTN);
        if (hist.size() > D + 2) void'(hist.pop_back());
        loaded = '0;
        if (m_hold == 0) begin
            for (int i = 0; i < 5; i++) begin
                if (m_pend[i]) begin
                    loaded[i] = 1'b1;
                    m_hold    = i + 1;
                    break;
                end
            end
        end else if (coin_ready) begin
            m_hold = 0;
        end
        m_ovf  = |(press & m_pend & ~loaded);
        m_pend = (m_pend & ~loaded) | press;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("valid", {31'd0, coin_valid}, {31'd0, m_hold != 0});
        chk("code", {29'd0, coin_code}, m_hold);
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        chk("btn_level", {27'd0, btn_level}, {27'd0, m_level});
    endtask

    task automatic step();
        if (coin_valid && coin_ready) begin
            deliv++;
            codes.push_back(int'(coin_code));
            if (coin_code == 3'd3) deliv3++;
        end
        @(posedge CLK);
        model_edge();
        #1;
        check_model();
        if (overflow) ovf_cnt++;
        level_seen |= btn_level;
    endtask

    task automatic clear_obs();
        deliv      = 0;
        deliv3     = 0;
        ovf_cnt    = 0;
        level_seen = '0;
        codes.delete();
    endtask

    task automatic do_reset();
        #2;
        RST = 1'b1;
        model_reset();
        #1;
        chk("rst_async_valid", {31'd0, coin_valid}, 32'd0);
        chk("rst_async_code", {29'd0, coin_code}, 32'd0);
        BTN        = '0;
        coin_ready = 1'b0;
        step();
        step();
        RST = 1'b0;
        clear_obs();
    endtask

    int first_v;
    int first_low;
    int code_at;
    int n;

    initial begin
        RST        = 1'b1;
        BTN        = '0;
        coin_ready = 1'b0;
        model_reset();
        clear_obs();
        step();
        chk("reset_level", {27'd0, btn_level}, 32'd0);
        chk("reset_overflow", {31'd0, overflow}, 32'd0);

        // Held coin button: valid after edge 7, gone after edge 8, single event.
        do_reset();
        BTN        = 5'b00001;
        coin_ready = 1'b1;
        first_v    = 0;
        first_low  = 0;
        code_at    = 0;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (coin_valid && first_v == 0) begin
                first_v = e;
                code_at = int'(coin_code);
            end
            if (!coin_valid && first_v != 0 && first_low == 0) first_low = e;
        end
        chk("coin25_rise_edge", first_v, 7);
        chk("coin25_code", code_at, 1);
        chk("coin25_fall_edge", first_low, 8);
        chk("coin25_count", deliv, 1);

        // Short glitch never debounces.
        do_reset();
        coin_ready = 1'b1;
        BTN        = 5'b01000;
        repeat (3) step();
        BTN = '0;
        repeat (12) step();
        chk("glitch_level", {31'd0, level_seen[3]}, 32'd0);
        chk("glitch_events", deliv, 0);

        // Simultaneous presses delivered in ascending index order.
        do_reset();
        coin_ready = 1'b1;
        BTN        = 5'b10010;
        repeat (16) step();
        chk("simul_count", codes.size(), 2);
        if (codes.size() == 2) begin
            chk("simul_first", codes[0], 2);
            chk("simul_second", codes[1], 5);
        end

        // Three presses against a stalled consumer: one overflow, two deliveries.
        do_reset();
        coin_ready = 1'b0;
        for (int ph = 0; ph < 5; ph++) begin
            BTN = (ph % 2 == 0) ? 5'b00100 : 5'b00000;
            repeat (10) step();
        end
        chk("stall_valid", {31'd0, coin_valid}, 32'd1);
        chk("stall_code", {29'd0, coin_code}, 32'd3);
        chk("stall_overflow", ovf_cnt, 1);
        coin_ready = 1'b1;
        repeat (10) step();
        chk("stall_delivered", deliv3, 2);
        BTN = '0;
        repeat (10) step();

        // Reset while holding an event; held button re-debounces from scratch.
        do_reset();
        BTN        = 5'b00001;
        coin_ready = 1'b0;
        n          = 0;
        while (!coin_valid && n < 20) begin
            step();
            n++;
        end
        chk("pre_rst_valid", {31'd0, coin_valid}, 32'd1);
        #2;
        RST = 1'b1;
        model_reset();
        #1;
        chk("mid_rst_valid", {31'd0, coin_valid}, 32'd0);
        chk("mid_rst_code", {29'd0, coin_code}, 32'd0);
        step();
        RST        = 1'b0;
        coin_ready = 1'b1;
        n          = 0;
        while (!coin_valid && n < 20) begin
            step();
            n++;
        end
        chk("post_rst_latency", n, 7);

        // Long hold yields one event; release yields none.
        do_reset();
        coin_ready = 1'b1;
        BTN        = 5'b00001;
        repeat (100) step();
        chk("long_hold_events", deliv, 1);
        BTN = '0;
        repeat (30) step();
        chk("release_events", deliv, 1);

        // Random traffic with occasional consumer stalls.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 5) == 0) BTN[$urandom_range(0, 4)] ^= 1'b1;
            coin_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
